param_universal_shift_register: RTL

//  Parametrised universal shift register with a command interface. One start pulse runs a

---
 rtl/param_universal_shift_register.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/param_universal_shift_register.sv
// Parametrised universal shift register with a start/busy/done command interface.
// One start pulse runs a multi-cycle shift or rotate of `count` single-bit steps,
// or applies a parallel load / clear in one edge. Serial ports at both ends allow
// cascading several registers.
// Optional feature macro: USR_ABORT_EN adds an abort input and an aborted pulse.
module param_universal_shift_register #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in_left,
  input  logic             serial_in_right,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out_left,
  output logic             serial_out_right,
  output logic             busy,
  output logic             done
`ifdef USR_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  localparam logic [2:0] ModeNop  = 3'b000;
  localparam logic [2:0] ModeShl  = 3'b001;
  localparam logic [2:0] ModeShr  = 3'b010;
  localparam logic [2:0] ModeRol  = 3'b011;
  localparam logic [2:0] ModeRor  = 3'b100;
  localparam logic [2:0] ModeAsr  = 3'b101;
  localparam logic [2:0] ModeLoad = 3'b110;
  localparam logic [2:0] ModeClr  = 3'b111;

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             done_q, done_d;
`ifdef USR_ABORT_EN
  logic             aborted_q, aborted_d;
`endif

  // One single-bit step of a shift/rotate mode; non-shift modes pass data through.
  function automatic logic [WIDTH-1:0] step_one(input logic [2:0]       m,
                                                input logic [WIDTH-1:0] d,
                                                input logic             sil,
                                                input logic             sir);
    logic [WIDTH-1:0] r;
    r = d;
    unique case (m)
      ModeShl: r = {d[WIDTH-2:0], sir};
      ModeShr: r = {sil, d[WIDTH-1:1]};
      ModeRol: r = {d[WIDTH-2:0], d[WIDTH-1]};
      ModeRor: r = {d[0], d[WIDTH-1:1]};
      ModeAsr: r = {d[WIDTH-1], d[WIDTH-1:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Modes 001..101 are multi-step shifts; the rest complete in IDLE.
  function automatic logic is_shift(input logic [2:0] m);
    return (m == ModeShl) || (m == ModeShr) || (m == ModeRol) ||
           (m == ModeRor) || (m == ModeAsr);
  endfunction

  // Next-state logic: command acceptance in IDLE, one step per edge in SHIFT.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    mode_d    = mode_q;
    remain_d  = remain_q;
    done_d    = 1'b0;
`ifdef USR_ABORT_EN
    aborted_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_shift(mode) && (count != '0)) begin
            // Latch the command; the first step happens on the following edge.
            mode_d   = mode;
            remain_d = count;
            state_d  = StShift;
          end else begin
            unique case (mode)
              ModeLoad: data_d = load_data;
              ModeClr:  data_d = '0;
              default:  data_d = data_q;  // NOP or zero-count shift
            endcase
            done_d = 1'b1;
          end
        end
      end
      StShift: begin
`ifdef USR_ABORT_EN
        if (abort) begin
          // Abort beats the final step: no step at this edge, no done.
          state_d   = StIdle;
          remain_d  = '0;
          aborted_d = 1'b1;
        end else
`endif
        begin
          data_d   = step_one(mode_q, data_q, serial_in_left, serial_in_right);
          remain_d = remain_q - 1'b1;
          if (remain_q == CNT_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset; reset discards any command in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      data_q    <= '0;
      mode_q    <= ModeNop;
      remain_q  <= '0;
      done_q    <= 1'b0;
`ifdef USR_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      mode_q    <= mode_d;
      remain_q  <= remain_d;
      done_q    <= done_d;
`ifdef USR_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  // Outputs are direct views of registered state.
  always_comb begin
    data_out         = data_q;
    serial_out_left  = data_q[WIDTH-1];
    serial_out_right = data_q[0];
    busy             = (state_q == StShift);
    done             = done_q;
`ifdef USR_ABORT_EN
    aborted          = aborted_q;
`endif
  end

endmodule
